// File: rtl/fetch_decode.sv
// Instruction sequencer: fetches 20-bit words over a req/ack port, decodes them
// for the alu for one EXEC cycle, and picks the next pc from the alu's jump decision.
module fetch_decode #(
  parameter int N = 19,
  parameter int M = 7,
  parameter int J = 3,
  parameter int A = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  output logic         imem_req,
  output logic [A-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N:0]   imem_rdata,
  output logic [J:0]   opc,
  output logic [3:0]   rd,
  output logic [3:0]   rs,
  output logic [M:0]   imm,
  output logic         exec_valid,
  output logic         wb_en,
  input  logic         jump_enable,
  output logic [A-1:0] pc,
  output logic         halted
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [J:0] OPC_ALU_LO = (J+1)'(1);
  localparam logic [J:0] OPC_ALU_HI = (J+1)'(8);
  localparam logic [J:0] OPC_BR9    = (J+1)'(9);
  localparam logic [J:0] OPC_BR10   = (J+1)'(10);
  localparam logic [J:0] OPC_BR11   = (J+1)'(11);
  localparam logic [J:0] OPC_BR12   = (J+1)'(12);
  localparam logic [J:0] OPC_BR14   = (J+1)'(14);
  localparam logic [J:0] OPC_HALT   = (J+1)'(15);

  logic [1:0]   state;
  logic [N:0]   ir;
  logic [A-1:0] jmp_tgt;
  logic [A-1:0] pc_inc;
  logic         is_branch;

  // Field layout: opc | rd | rs | imm, packed from the MSB down.
  assign opc = ir[N -: J+1];
  assign rd  = ir[M+8 -: 4];
  assign rs  = ir[M+4 -: 4];
  assign imm = ir[M:0];

  // Outputs are pure decodes of state so an async reset clears them at once.
  assign imem_req   = (state == S_FETCH);
  assign imem_addr  = pc;
  assign exec_valid = (state == S_EXEC);
  assign halted     = (state == S_HALT);
  assign wb_en      = exec_valid && (opc >= OPC_ALU_LO) && (opc <= OPC_ALU_HI);

  assign is_branch = (opc == OPC_BR9)  || (opc == OPC_BR10) || (opc == OPC_BR11) ||
                     (opc == OPC_BR12) || (opc == OPC_BR14);
  assign pc_inc    = pc + A'(1);

  generate
    if (A > M + 1) begin : g_tgt_zext
      assign jmp_tgt = {{(A-M-1){1'b0}}, imm};
    end else begin : g_tgt_trunc
      assign jmp_tgt = imm[A-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      case (state)
        S_IDLE: if (run) state <= S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (opc == OPC_HALT) begin
            state <= S_HALT;
          end else begin
            state <= S_FETCH;
            pc    <= (is_branch && jump_enable) ? jmp_tgt : pc_inc;
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule
